// File: rtl/stream_mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : stream_mux_arb_pkg
// Purpose : Shared constants and helpers for the registered stream mux and
//           its round-robin arbiter.
// Contents: MODE_SELECT / MODE_RR mode encodings, clog2_safe() width helper.
// Revision: 1.0 - initial release
// ============================================================================
package stream_mux_arb_pkg;

  localparam int MODE_SELECT = 0;  // explicit channel select via sel
  localparam int MODE_RR     = 1;  // round-robin arbitration, sel ignored

  // Index width for an n-entry set. A single entry still needs a 1-bit
  // index so that select/source ports never collapse to zero width.
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_arb_if.sv
`default_nettype none
// ============================================================================
// Interface : stream_mux_arb_if
// Purpose   : Bundles the N producer channels and the single consumer channel
//             of the stream mux.
// Signals   : in_data/in_valid/in_ready - packed producer channels
//             sel                       - explicit select (select mode only)
//             flush                     - discard output register
//             out_data/out_valid/out_ready/out_src - consumer channel
// Modports  : master - producer/consumer environment side
//             slave  - mux side
// Revision  : 1.0 - initial release
// ============================================================================
interface stream_mux_arb_if
  import stream_mux_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 5,
  parameter int SEL_WIDTH  = clog2_safe(NUM_IN)
) ();

  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN-1:0]            in_ready;
  logic [SEL_WIDTH-1:0]         sel;
  logic                         flush;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [SEL_WIDTH-1:0]         out_src;

  modport master (
    output in_data, in_valid, sel, flush, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, sel, flush, out_ready,
    output in_ready, out_data, out_valid, out_src
  );

endinterface
`default_nettype wire

// File: rtl/stream_mux_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : stream_mux_arb_rr_arbiter
// Purpose : Combinational rotating-priority arbiter. Grants the first
//           requester found scanning ptr_i, ptr_i+1, ... modulo NUM_IN.
// Ports   : valid_i    [NUM_IN]    - request vector
//           ptr_i      [SEL_WIDTH] - highest-priority index (must be < NUM_IN)
//           grant_o    [SEL_WIDTH] - granted index (0 when grant_ok_o=0)
//           grant_ok_o             - at least one request present
// Revision: 1.0 - initial release
// ============================================================================
module stream_mux_arb_rr_arbiter
  import stream_mux_arb_pkg::*;
#(
  parameter int NUM_IN    = 5,
  parameter int SEL_WIDTH = clog2_safe(NUM_IN)
) (
  input  logic [NUM_IN-1:0]    valid_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [SEL_WIDTH-1:0] grant_o,
  output logic                 grant_ok_o
);

  // Rotating the doubled request vector right by ptr_i puts channel ptr_i at
  // bit 0, so a plain lowest-bit-first search yields the rotated priority.
  logic [2*NUM_IN-1:0]  dbl;
  logic [NUM_IN-1:0]    rot;
  logic [SEL_WIDTH:0]   idx;

  assign dbl = {valid_i, valid_i};
  assign rot = NUM_IN'(dbl >> ptr_i);

  always_comb begin
    grant_o    = '0;
    grant_ok_o = 1'b0;
    idx        = '0;
    // Descending scan: the last hit written is the lowest offset.
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = {1'b0, ptr_i} + (SEL_WIDTH + 1)'(k);
        if (idx >= (SEL_WIDTH + 1)'(NUM_IN)) begin
          idx = idx - (SEL_WIDTH + 1)'(NUM_IN);
        end
        grant_o    = idx[SEL_WIDTH-1:0];
        grant_ok_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module  : stream_mux_arb
// Purpose : N-input stream multiplexer with valid/ready handshakes and a
//           one-stage output register. Channel choice is either an explicit
//           select (MODE_SELECT) or round-robin arbitration (MODE_RR).
// Ports   : clk   - clock, all state on rising edge
//           rst_n - asynchronous active-low reset
//           bus   - stream_mux_arb_if.slave (producer channels, sel, flush,
//                   registered consumer channel with source index)
// Revision: 1.0 - initial release
// ============================================================================
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 5,
  parameter int MODE       = MODE_SELECT
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_arb_if.slave bus
);

  localparam int SEL_WIDTH = clog2_safe(NUM_IN);

  logic [SEL_WIDTH-1:0]  grant;
  logic                  grant_ok;
  logic                  can_accept;
  logic                  accept;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  grant_valid;
  logic [NUM_IN-1:0]     in_ready;

  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0]  out_src_q,   out_src_d;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

      stream_mux_arb_rr_arbiter #(
        .NUM_IN    (NUM_IN),
        .SEL_WIDTH (SEL_WIDTH)
      ) u_arb (
        .valid_i    (bus.in_valid),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .grant_ok_o (grant_ok)
      );

      // Pointer moves only on an accepted word, to just past the winner.
      always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
          rr_ptr_d = (grant == SEL_WIDTH'(NUM_IN - 1)) ? '0 : grant + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rr_ptr_q <= '0;
        end else begin
          rr_ptr_q <= rr_ptr_d;
        end
      end
    end else begin : g_sel
      // Out-of-range select grants nothing rather than defaulting to channel 0.
      assign grant    = bus.sel;
      assign grant_ok = ({1'b0, bus.sel} < (SEL_WIDTH + 1)'(NUM_IN));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // Output slot is free if empty or being drained this cycle; flush blocks
  // new words so that the flushed cycle never consumes a producer word.
  assign can_accept = (!out_valid_q || bus.out_ready) && !bus.flush;

  always_comb begin
    grant_data  = '0;
    grant_valid = 1'b0;
    in_ready    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        grant_data  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        grant_valid = bus.in_valid[i];
        in_ready[i] = can_accept && grant_ok;
      end
    end
  end

  assign accept       = grant_valid && can_accept && grant_ok;
  assign bus.in_ready = in_ready;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      // Covers both fill-from-empty and replace-while-draining.
      out_data_d  = grant_data;
      out_src_d   = grant;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_mux_arb
// Purpose : Self-checking bench for stream_mux_arb. One instance in select
//           mode, one in round-robin mode, both NUM_IN=5, DATA_WIDTH=32.
//           Stimulus pushes expected output words into per-instance queues;
//           monitors pop and compare on every output transfer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_mux_arb;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  logic [34:0] q0[$];
  logic [34:0] q1[$];

  stream_mux_arb_if #(.DATA_WIDTH(32), .NUM_IN(5)) if0 ();
  stream_mux_arb_if #(.DATA_WIDTH(32), .NUM_IN(5)) if1 ();

  stream_mux_arb #(.DATA_WIDTH(32), .NUM_IN(5), .MODE(0)) u_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  stream_mux_arb #(.DATA_WIDTH(32), .NUM_IN(5), .MODE(1)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: a word leaves on out_valid & out_ready unless flushed.
  always @(negedge clk) begin
    if (rst_n && if0.out_valid && if0.out_ready && !if0.flush) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL sel_unexpected_word: got %0h expected none", {if0.out_src, if0.out_data});
      end else begin
        chk("sel_word", {29'd0, if0.out_src, if0.out_data}, {29'd0, q0.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if1.out_valid && if1.out_ready && !if1.flush) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL rr_unexpected_word: got %0h expected none", {if1.out_src, if1.out_data});
      end else begin
        chk("rr_word", {29'd0, if1.out_src, if1.out_data}, {29'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if0.in_data[i*32 +: 32] = 32'hCAFE0000 + i;
      if1.in_data[i*32 +: 32] = 32'hBEEF0000 + i;
    end
    if0.in_valid = 5'b11111;  if1.in_valid = 5'b11111;
    if0.sel = 3'd0;           if1.sel = 3'd0;
    if0.flush = 1'b0;         if1.flush = 1'b0;
    if0.out_ready = 1'b1;     if1.out_ready = 1'b1;

    // ---- reset with all inputs valid ----
    repeat (2) begin
      @(negedge clk);
      chk("rst_sel_valid", if0.out_valid, 0);
      chk("rst_sel_data",  if0.out_data,  0);
      chk("rst_sel_src",   if0.out_src,   0);
      chk("rst_rr_valid",  if1.out_valid, 0);
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_sel_valid", if0.out_valid, 0);
    chk("rel_sel_data",  if0.out_data,  0);
    chk("rel_sel_src",   if0.out_src,   0);
    chk("rel_rr_valid",  if1.out_valid, 0);
    chk("rel_rr_data",   if1.out_data,  0);
    if0.in_valid = 5'b00000;
    if1.in_valid = 5'b00000;

    // ---- select mode: sel=2 ----
    cyc();
    if0.sel = 3'd2;
    if0.in_valid = 5'b00100;
    q0.push_back({3'd2, 32'hCAFE0002});
    @(negedge clk);
    chk("sel2_in_ready", if0.in_ready, 5'b00100);
    cyc();
    if0.in_valid = 5'b00000;
    @(negedge clk);
    chk("sel2_out_valid", if0.out_valid, 1);

    // ---- select mode: out-of-range sel ----
    cyc();
    if0.sel = 3'd6;
    if0.in_valid = 5'b11111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("sel6_in_ready",  if0.in_ready,  0);
      chk("sel6_out_valid", if0.out_valid, 0);
    end
    cyc();
    if0.in_valid = 5'b00000;
    if0.sel = 3'd0;

    // ---- round robin: all valid, expect 0,1,2,3,4,0 ----
    cyc();
    if1.in_valid = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      q1.push_back({3'(k % 5), 32'hBEEF0000 + 32'(k % 5)});
      @(negedge clk);
      chk("rr_all_in_ready", if1.in_ready, 5'b00001 << (k % 5));
      if (k > 0) chk("rr_all_out_valid", if1.out_valid, 1);
    end
    cyc();
    if1.in_valid = 5'b00000;
    @(negedge clk);
    chk("rr_all_last_valid", if1.out_valid, 1);

    // ---- round robin: channels 1 and 3, starting from pointer 2 ----
    cyc();
    if1.in_valid = 5'b00010;              // pointer 1 -> grant 1, pointer -> 2
    q1.push_back({3'd1, 32'hBEEF0001});
    @(negedge clk);
    chk("rr13_pre_in_ready", if1.in_ready, 5'b00010);
    cyc();
    if1.in_valid = 5'b01010;
    q1.push_back({3'd3, 32'hBEEF0003});
    @(negedge clk);
    chk("rr13_g3_in_ready", if1.in_ready, 5'b01000);
    cyc();
    q1.push_back({3'd1, 32'hBEEF0001});
    @(negedge clk);
    chk("rr13_g1_in_ready", if1.in_ready, 5'b00010);
    cyc();
    q1.push_back({3'd3, 32'hBEEF0003});
    @(negedge clk);
    chk("rr13_g3b_in_ready", if1.in_ready, 5'b01000);

    // stall with the channel-3 word held
    cyc();
    if1.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready",  if1.in_ready,  0);
      chk("stall_out_valid", if1.out_valid, 1);
      chk("stall_out_src",   if1.out_src,   3);
      chk("stall_out_data",  if1.out_data,  32'hBEEF0003);
    end
    cyc();
    if1.out_ready = 1'b1;
    if1.in_valid = 5'b00000;
    @(negedge clk);

    // ---- flush: pointer 4 -> grant 0, pointer -> 1 ----
    cyc();
    if1.in_valid = 5'b00001;
    @(negedge clk);
    chk("fl_pre_in_ready", if1.in_ready, 5'b00001);
    cyc();
    if1.flush = 1'b1;
    if1.in_valid = 5'b00101;
    @(negedge clk);
    chk("fl_in_ready",  if1.in_ready,  0);
    chk("fl_out_valid", if1.out_valid, 1);
    chk("fl_out_src",   if1.out_src,   0);
    cyc();
    if1.flush = 1'b0;
    if1.in_valid = 5'b00000;
    @(negedge clk);
    chk("fl_post_valid", if1.out_valid, 0);
    cyc();
    if1.in_valid = 5'b11111;              // pointer still 1
    q1.push_back({3'd1, 32'hBEEF0001});
    @(negedge clk);
    chk("fl_ptr_in_ready", if1.in_ready, 5'b00010);
    cyc();
    if1.in_valid = 5'b00000;
    @(negedge clk);
    cyc();
    @(negedge clk);

    chk("sel_queue_empty", 64'(q0.size()), 0);
    chk("rr_queue_empty",  64'(q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
